// File: rtl/cpu_rst_seq.sv
// Staged reset sequencer for the cpu_clk domain: waits for a stable PLL lock,
// releases peripheral reset, then CPU reset, and honours a debounced reset button.
module cpu_rst_seq #(
  parameter int LOCK_HOLD = 1024,
  parameter int DEBOUNCE  = 22000,
  parameter int STAGGER   = 16,
  parameter int CNT_W     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_pll_locked,
  input  logic       i_btn_rst,
  output logic       o_periph_rst,
  output logic       o_cpu_rst,
  output logic       o_ready,
  output logic       o_lock_lost,
  output logic [7:0] o_lost_cnt
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    BTN_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

  logic             r_lockMeta;
  logic             r_lockS;
  logic             r_btnMeta;
  logic             r_btnS;
  logic [CNT_W-1:0] r_dbc;
  logic             r_btnD;
  logic             r_btnDPrev;
  logic             w_press;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_lossCount;
  logic [CNT_W-1:0] r_cnt;
  logic             r_periphRst;
  logic             r_cpuRst;
  logic             r_ready;
  logic             r_lockLost;
  logic [7:0]       r_lostCnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lockMeta <= 1'b0;
      r_lockS    <= 1'b0;
      r_btnMeta  <= 1'b0;
      r_btnS     <= 1'b0;
    end else begin
      r_lockMeta <= i_pll_locked;
      r_lockS    <= r_lockMeta;
      r_btnMeta  <= i_btn_rst;
      r_btnS     <= r_btnMeta;
    end
  end

  // Any cycle of agreement restarts the debounce window.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dbc      <= '0;
      r_btnD     <= 1'b0;
      r_btnDPrev <= 1'b0;
    end else begin
      r_btnDPrev <= r_btnD;
      if (r_btnS != r_btnD) begin
        if (r_dbc == DEB_LAST) begin
          r_btnD <= r_btnS;
          r_dbc  <= '0;
        end else begin
          r_dbc <= r_dbc + CNT_W'(1);
        end
      end else begin
        r_dbc <= '0;
      end
    end
  end

  assign w_press = r_btnD & ~r_btnDPrev;

  always_comb begin
    w_nextState = r_state;
    w_lossCount = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        if (r_lockS) w_nextState = STABLE;
      end
      STABLE: begin
        if (!r_lockS)                w_nextState = WAIT_LOCK;
        else if (r_btnD)             w_nextState = BTN_HOLD;
        else if (r_cnt == LOCK_LAST) w_nextState = RELEASE;
      end
      RELEASE: begin
        if (!r_lockS) begin
          w_nextState = WAIT_LOCK;
          w_lossCount = 1'b1;
        end else if (w_press) begin
          w_nextState = BTN_HOLD;
        end else if (r_cnt == STAG_LAST) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (!r_lockS) begin
          w_nextState = WAIT_LOCK;
          w_lossCount = 1'b1;
        end else if (w_press) begin
          w_nextState = BTN_HOLD;
        end
      end
      BTN_HOLD: begin
        if (!r_lockS)     w_nextState = WAIT_LOCK;
        else if (!r_btnD) w_nextState = STABLE;
      end
      default: w_nextState = WAIT_LOCK;
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_periphRst <= 1'b1;
      r_cpuRst    <= 1'b1;
      r_ready     <= 1'b0;
      r_lockLost  <= 1'b0;
      r_lostCnt   <= 8'd0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state)
        r_cnt <= '0;
      else if (r_state == STABLE || r_state == RELEASE)
        r_cnt <= r_cnt + CNT_W'(1);
      r_periphRst <= (w_nextState inside {WAIT_LOCK, STABLE, BTN_HOLD});
      r_cpuRst    <= (w_nextState != RUN);
      r_ready     <= (w_nextState == RUN);
      if (w_lossCount) begin
        r_lockLost <= 1'b1;
        if (r_lostCnt != 8'hFF) r_lostCnt <= r_lostCnt + 8'd1;
      end
    end
  end

  assign o_periph_rst = r_periphRst;
  assign o_cpu_rst    = r_cpuRst;
  assign o_ready      = r_ready;
  assign o_lock_lost  = r_lockLost;
  assign o_lost_cnt   = r_lostCnt;

endmodule

// File: tb/tb_cpu_rst_seq.sv
// Bench for cpu_rst_seq: a countdown-based reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and flag values.
module tb_cpu_rst_seq;

  localparam int LH = 8;
  localparam int DB = 4;
  localparam int ST = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       pllLocked;
  logic       btnRst;
  logic       periphRst;
  logic       cpuRst;
  logic       ready;
  logic       lockLost;
  logic [7:0] lostCnt;

  int testsRun    = 0;
  int testsFailed = 0;
  int n;

  always #5 clock = ~clock;

  cpu_rst_seq #(
    .LOCK_HOLD(LH),
    .DEBOUNCE (DB),
    .STAGGER  (ST),
    .CNT_W    (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i_pll_locked(pllLocked),
    .i_btn_rst   (btnRst),
    .o_periph_rst(periphRst),
    .o_cpu_rst   (cpuRst),
    .o_ready     (ready),
    .o_lock_lost (lockLost),
    .o_lost_cnt  (lostCnt)
  );

  // Reference model: phases with a countdown of cycles left before the next release step.
  typedef enum {M_WAIT, M_STABLE, M_RELEASE, M_RUN, M_HOLD} phase_t;
  phase_t mPhase = M_WAIT;
  phase_t mNext;
  bit mLk1, mLk2, mBt1, mBt2, mBtnD, mBtnDPrev, mLockLost, mValid;
  bit mPress, mGone;
  int mDiffRun, mLeft, mLost;

  always @(posedge clock) begin
    if (reset) begin
      mPhase = M_WAIT; mLk1 = 0; mLk2 = 0; mBt1 = 0; mBt2 = 0;
      mBtnD = 0; mBtnDPrev = 0; mLockLost = 0; mDiffRun = 0; mLeft = 0; mLost = 0;
      mValid = 1;
    end else begin
      mPress = mBtnD && !mBtnDPrev;
      mGone  = !mLk2;
      mNext  = mPhase;
      case (mPhase)
        M_WAIT:
          if (!mGone) begin mNext = M_STABLE; mLeft = LH; end
        M_STABLE:
          if (mGone) mNext = M_WAIT;
          else if (mBtnD) mNext = M_HOLD;
          else begin
            mLeft--;
            if (mLeft == 0) begin mNext = M_RELEASE; mLeft = ST; end
          end
        M_RELEASE, M_RUN:
          if (mGone) begin
            mNext = M_WAIT;
            mLockLost = 1;
            if (mLost < 255) mLost++;
          end else if (mPress) begin
            mNext = M_HOLD;
          end else if (mPhase == M_RELEASE) begin
            mLeft--;
            if (mLeft == 0) mNext = M_RUN;
          end
        M_HOLD:
          if (mGone) mNext = M_WAIT;
          else if (!mBtnD) begin mNext = M_STABLE; mLeft = LH; end
        default: mNext = M_WAIT;
      endcase
      mPhase = mNext;
      mBtnDPrev = mBtnD;
      if (mBt2 != mBtnD) begin
        mDiffRun++;
        if (mDiffRun == DB) begin mBtnD = mBt2; mDiffRun = 0; end
      end else begin
        mDiffRun = 0;
      end
      mLk2 = mLk1; mLk1 = pllLocked;
      mBt2 = mBt1; mBt1 = btnRst;
    end
  end

  // Per-cycle comparison of every output against the model, plus the reset ordering invariant.
  initial begin
    logic [11:0] act, exp;
    forever begin
      @(posedge clock);
      #1;
      if (mValid) begin
        act = {periphRst, cpuRst, ready, lockLost, lostCnt};
        exp = {(mPhase == M_WAIT || mPhase == M_STABLE || mPhase == M_HOLD),
               (mPhase != M_RUN), (mPhase == M_RUN), mLockLost, 8'(mLost)};
        testsRun++;
        if (act !== exp || (cpuRst === 1'b0 && periphRst !== 1'b0)) begin
          testsFailed++;
          $display("[TB] FAIL modelCompare t=%0t actual=%b expected=%b", $time, act, exp);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit lock, input bit btn, input bit rst, input int cycles);
    pllLocked = lock;
    btnRst    = btn;
    reset     = rst;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_periph"}, periphRst, 1);
    checkOutput({tag, "_cpu"}, cpuRst, 1);
    checkOutput({tag, "_ready"}, ready, 0);
    checkOutput({tag, "_lockLost"}, lockLost, 0);
    checkOutput({tag, "_lostCnt"}, lostCnt, 0);
  endtask

  task automatic measurePeriphFall(input string name, input int expected);
    int k = 0;
    while (periphRst !== 1'b0 && k < 60) begin @(negedge clock); k++; end
    checkOutput(name, k, expected);
  endtask

  task automatic measureCpuFall(input string name, input int expected);
    int k = 0;
    while (cpuRst !== 1'b0 && k < 60) begin @(negedge clock); k++; end
    checkOutput(name, k, expected);
  endtask

  initial begin
    // Cold start with lock present from the beginning.
    applyStimulus(1, 0, 1, 2);
    checkResetValues("reset");
    reset = 0;
    measurePeriphFall("coldPeriphDelay", 11);
    measureCpuFall("coldCpuDelay", 3);
    checkOutput("coldReady", ready, 1);

    // One-cycle lock glitch while counting in STABLE restarts the hold.
    applyStimulus(1, 0, 1, 1);
    applyStimulus(1, 0, 0, 6);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 3);
    checkOutput("glitchPeriph", periphRst, 1);
    checkOutput("glitchLockLost", lockLost, 0);
    checkOutput("glitchLostCnt", lostCnt, 0);
    measurePeriphFall("glitchRestartDelay", 8);
    measureCpuFall("glitchCpuDelay", 3);

    // Lock loss in RUN is counted and the full sequence repeats on relock.
    applyStimulus(0, 0, 0, 2);
    checkOutput("lossSyncReady", ready, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("lossPeriph", periphRst, 1);
    checkOutput("lossCpu", cpuRst, 1);
    checkOutput("lossReady", ready, 0);
    checkOutput("lossLockLost", lockLost, 1);
    checkOutput("lossLostCnt", lostCnt, 1);
    pllLocked = 1;
    measurePeriphFall("relockPeriphDelay", 11);
    measureCpuFall("relockCpuDelay", 3);

    // Bouncing button never produces a press.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 2);
      applyStimulus(1, 0, 0, 2);
    end
    checkOutput("bounceReady", ready, 1);
    checkOutput("bouncePeriph", periphRst, 0);

    // Held press asserts both resets after sync + debounce + one edge.
    btnRst = 1;
    n = 0;
    while (periphRst !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    checkOutput("pressDelay", n, 7);
    checkOutput("pressCpu", cpuRst, 1);
    applyStimulus(1, 1, 0, 3);
    checkOutput("holdReady", ready, 0);
    btnRst = 0;
    measureCpuFall("releaseToRun", 18);
    checkOutput("releaseReady", ready, 1);

    // Lock loss and press reach the FSM in the same cycle: loss wins and is counted.
    applyStimulus(1, 1, 0, 4);
    applyStimulus(0, 1, 0, 3);
    checkOutput("simulPeriph", periphRst, 1);
    checkOutput("simulReady", ready, 0);
    checkOutput("simulLostCnt", lostCnt, 2);
    applyStimulus(0, 0, 0, 8);
    applyStimulus(1, 0, 0, 16);
    checkOutput("simulRecoverReady", ready, 1);

    // Repeated losses saturate the counter.
    for (int i = 0; i < 260; i++) begin
      applyStimulus(0, 0, 0, 4);
      applyStimulus(1, 0, 0, 16);
    end
    checkOutput("satLostCnt", lostCnt, 255);
    checkOutput("satReady", ready, 1);

    // Reset in the middle of RELEASE restores everything.
    applyStimulus(0, 0, 0, 4);
    applyStimulus(1, 0, 0, 12);
    checkOutput("midReleasePeriph", periphRst, 0);
    checkOutput("midReleaseCpu", cpuRst, 1);
    applyStimulus(1, 0, 1, 1);
    checkResetValues("midReset");
    applyStimulus(1, 0, 0, 16);
    checkOutput("finalReady", ready, 1);
    checkOutput("finalLostCnt", lostCnt, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
